alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 32-bit datapath ALU: eight operations selected by a 3-bit opcode over WIDTH-bit operands, with registered outputs, status flags and an iterative unsigned modulo unit. Sits between the register-file read stage and write-back. Single-cycle operations accept a new request every clock. MOD runs as a WIDTH-step restoring division under a start/busy/valid handshake.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk; 0 = reset.
- start  in  1  request strobe; accepted only when busy = 0.
- op  in  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT (signed), 101 ADD, 110 SUB, 111 MOD (unsigned).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- result  out  WIDTH  registered result; holds until the next completion.
- valid  out  1  one-cycle pulse: result and flags updated this cycle.
- busy  out  1  high while MOD iteration is in progress.
- zero  out  1  result == 0, registered with result.
- ovf  out  1  signed overflow; ADD and SUB only, else 0.
- dbz  out  1  MOD with b == 0; else 0.

## Operation
- States: IDLE, DIV. Reset to IDLE.
- Reset (reset = 0 at an edge): result = 0, valid = 0, busy = 0, zero = 0, ovf = 0, dbz = 0, state = IDLE, iteration counter = 0. An in-flight MOD is aborted with no valid.
- IDLE, start = 1, op ≠ 111: compute combinationally from a, b. Register result and flags at the same edge. valid = 1 for the following cycle. Stay in IDLE.
- IDLE, start = 1, op = 111, b == 0: result = a, dbz = 1, valid pulse. Stay in IDLE with no iteration.
- IDLE, start = 1, op = 111, b ≠ 0: latch a (dividend shift register) and b (divisor). Clear the (WIDTH+1)-bit partial remainder. Load counter = WIDTH. busy = 1. Go to DIV.
- DIV, each edge:
  - remainder = {remainder, dividend MSB}; shift dividend left.
  - If remainder ≥ divisor, subtract the divisor.
  - Decrement counter.
- DIV, step with counter == 1: register the final remainder into result, with zero set from it and ovf = 0, dbz = 0. valid pulse. busy = 0. Go to IDLE.
- start while busy = 1: ignored; a, b, op are not re-sampled.
- start = 0 in IDLE: outputs hold; valid = 0.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf on ADD = (a[MSB] == b[MSB]) && (sum[MSB] ≠ a[MSB]).
  - ovf on SUB = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]).
  - SLT result = 1 if signed a < signed b, else 0, zero-extended.
  - NOR = ~(a | b) over WIDTH bits.
- zero is evaluated on every completion, including MOD and dbz.

## Timing
- Single-cycle ops: latency 1. A start sampled at edge E0 gives valid in the cycle after E0. Throughput is 1 per clock; back-to-back starts yield consecutive valid pulses.
- MOD, b ≠ 0: start at E0. busy is high after E0. Iterations run on E1..E_WIDTH; result and valid are written at E_WIDTH, so latency = WIDTH+1. busy falls at E_WIDTH. The next start is accepted at E_WIDTH+1.
- MOD, b == 0: latency 1; busy never asserted.
- busy and valid are never high in the same cycle.
- Reset asserted concurrently with start: reset wins; the request is dropped.

## Test plan
- Reset: hold reset = 0 for 2 edges with start = 1, op = 101 -> all outputs 0, no valid.
- Logic/arith, WIDTH = 32, back-to-back starts, one per clock -> consecutive valid pulses, latency 1 each:
  - a = 0xF0F0_00FF, b = 0x0F0F_0F0F, ops 000..011 -> 0x0000_000F, 0xFFFF_0FFF, 0xFFFF_0FF0, 0x0000_F000.
  - ADD 0x7FFF_FFFF + 1 -> 0x8000_0000, ovf = 1.
  - SUB 5 − 5 -> 0, zero = 1, ovf = 0.
  - SLT a = 0xFFFF_FFFF, b = 1 -> 1.
- MOD, WIDTH = 32, a = 1000, b = 7:
  - busy high for exactly 32 cycles.
  - valid exactly 33 cycles after start; result = 6.
  - Extra starts during busy are ignored.
- MOD by zero: a = 0x1234, b = 0 -> result = 0x1234, dbz = 1, latency 1, busy stays 0.
- Reset mid-MOD: start MOD at E0, reset = 0 at E10 -> busy = 0, no valid; a fresh ADD 2 + 3 at the next edge -> result = 5.
- WIDTH = 8 instance:
  - MOD a = 0xFF, b = 0x10 -> 0x0F after 9 cycles.
  - ADD 0x80 + 0x80 -> 0x00, zero = 1, ovf = 1.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq request/response bundle.
// master drives the request, slave returns result and status.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             busy;
  logic             zero;
  logic             ovf;
  logic             dbz;

  modport master (
    output start, op, a, b,
    input  result, valid, busy, zero, ovf, dbz
  );

  modport slave (
    input  start, op, a, b,
    output result, valid, busy, zero, ovf, dbz
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus an
// iterative restoring unsigned modulo under busy/valid.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, DIV} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic             r_busy;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dbz;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu;
  logic             w_ovf;
  logic             w_slt;
  logic [WIDTH+1:0] w_shift;
  logic             w_ge;
  logic [WIDTH:0]   w_rem;

  always_comb begin
    w_sum  = bus.a + bus.b;
    w_diff = bus.a - bus.b;
    w_slt  = $signed(bus.a) < $signed(bus.b);
    w_alu  = '0;
    w_ovf  = 1'b0;
    unique case (bus.op)
      3'b000: w_alu = bus.a & bus.b;
      3'b001: w_alu = bus.a | bus.b;
      3'b010: w_alu = bus.a ^ bus.b;
      3'b011: w_alu = ~(bus.a | bus.b);
      3'b100: w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      3'b101: begin
        w_alu = w_sum;
        w_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b110: begin
        w_alu = w_diff;
        w_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b111: w_alu = bus.a;
    endcase
  end

  // one restoring step: shift in dividend MSB, subtract if it fits
  always_comb begin
    w_shift = {r_rem, r_dvd[WIDTH-1]};
    w_ge    = w_shift >= {2'b00, r_dvs};
    w_rem   = (WIDTH+1)'(w_ge ? w_shift - {2'b00, r_dvs}
                                : w_shift);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.op != 3'b111) begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
              r_ovf    <= w_ovf;
              r_dbz    <= 1'b0;
              r_valid  <= 1'b1;
            end else if (bus.b == '0) begin
              r_result <= bus.a;
              r_zero   <= (bus.a == '0);
              r_ovf    <= 1'b0;
              r_dbz    <= 1'b1;
              r_valid  <= 1'b1;
            end else begin
              r_dvd   <= bus.a;
              r_dvs   <= bus.b;
              r_rem   <= '0;
              r_cnt   <= CW'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= DIV;
            end
          end
        end
        DIV: begin
          r_rem <= w_rem;
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result <= w_rem[WIDTH-1:0];
            r_zero   <= (w_rem[WIDTH-1:0] == '0);
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;
  assign bus.zero   = r_zero;
  assign bus.ovf    = r_ovf;
  assign bus.dbz    = r_dbz;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH 32 and WIDTH 8.
// Expected results are queued at issue and checked on valid.
module tb_alu_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  typedef struct {
    logic [63:0] res;
    logic        z;
    logic        o;
    logic        d;
    int          due;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  alu_seq_if #(.WIDTH(32)) if32();
  alu_seq_if #(.WIDTH(8))  if8();

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk  (clk),
    .reset(reset),
    .bus  (if32.slave)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (if8.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w,
                                 input logic [2:0] op,
                                 input logic [63:0] ai,
                                 input logic [63:0] bi);
    exp_t e;
    logic [63:0] m, a, b, r;
    logic sa, sb;
    m = (64'h1 << w) - 64'h1;
    a = ai & m;
    b = bi & m;
    sa = a[w-1];
    sb = b[w-1];
    e.o = 1'b0;
    e.d = 1'b0;
    r = '0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b) & m;
      3'd4: r = (sa != sb) ? {63'b0, sa} : {63'b0, a < b};
      3'd5: begin
        r = (a + b) & m;
        e.o = (sa == sb) && (r[w-1] != sa);
      end
      3'd6: begin
        r = (a - b) & m;
        e.o = (sa != sb) && (r[w-1] != sa);
      end
      default: begin
        if (b == 0) begin
          r = a;
          e.d = 1'b1;
        end else begin
          r = a % b;
        end
      end
    endcase
    e.res = r;
    e.z = (r == 0);
    e.due = 0;
    return e;
  endfunction

  task automatic drive32(input logic [2:0] op,
                         input logic [63:0] a,
                         input logic [63:0] b,
                         input bit push);
    exp_t e;
    if32.start = 1'b1;
    if32.op = op;
    if32.a = a[31:0];
    if32.b = b[31:0];
    if (push) begin
      e = model(32, op, a, b);
      e.due = cyc + ((op == 3'd7 && b[31:0] != 0) ? 33 : 1);
      q32.push_back(e);
    end
    @(negedge clk);
    if32.start = 1'b0;
  endtask

  task automatic drive8(input logic [2:0] op,
                        input logic [63:0] a,
                        input logic [63:0] b);
    exp_t e;
    if8.start = 1'b1;
    if8.op = op;
    if8.a = a[7:0];
    if8.b = b[7:0];
    e = model(8, op, a, b);
    e.due = cyc + ((op == 3'd7 && b[7:0] != 0) ? 9 : 1);
    q8.push_back(e);
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q32.size() == 0 && q8.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(q32.size() + q8.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && if32.busy === 1'b1) busy_cnt++;
    if (reset && if32.valid === 1'b1) begin
      chk("busy_valid32", {63'b0, if32.busy}, 64'd0);
      chk("pending32", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("res32", 64'(if32.result), e.res);
        chk("zero32", {63'b0, if32.zero}, {63'b0, e.z});
        chk("ovf32", {63'b0, if32.ovf}, {63'b0, e.o});
        chk("dbz32", {63'b0, if32.dbz}, {63'b0, e.d});
        chk("lat32", 64'(cyc), 64'(e.due));
      end
    end
    if (reset && if8.valid === 1'b1) begin
      chk("busy_valid8", {63'b0, if8.busy}, 64'd0);
      chk("pending8", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("res8", 64'(if8.result), e.res);
        chk("zero8", {63'b0, if8.zero}, {63'b0, e.z});
        chk("ovf8", {63'b0, if8.ovf}, {63'b0, e.o});
        chk("dbz8", {63'b0, if8.dbz}, {63'b0, e.d});
        chk("lat8", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    if32.start = 1'b1;
    if32.op = 3'b101;
    if32.a = 32'd2;
    if32.b = 32'd3;
    if8.start = 1'b1;
    if8.op = 3'b101;
    if8.a = 8'd2;
    if8.b = 8'd3;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", 64'(if32.result), 64'd0);
    chk("rst_valid", {63'b0, if32.valid}, 64'd0);
    chk("rst_busy", {63'b0, if32.busy}, 64'd0);
    chk("rst_zero", {63'b0, if32.zero}, 64'd0);
    chk("rst_ovf", {63'b0, if32.ovf}, 64'd0);
    chk("rst_dbz", {63'b0, if32.dbz}, 64'd0);
    chk("rst_valid8", {63'b0, if8.valid}, 64'd0);
    if32.start = 1'b0;
    if8.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    drive32(3'd0, 64'hF0F0_00FF, 64'h0F0F_0F0F, 1);
    drive32(3'd1, 64'hF0F0_00FF, 64'h0F0F_0F0F, 1);
    drive32(3'd2, 64'hF0F0_00FF, 64'h0F0F_0F0F, 1);
    drive32(3'd3, 64'hF0F0_00FF, 64'h0F0F_0F0F, 1);
    drive32(3'd5, 64'h7FFF_FFFF, 64'h1, 1);
    drive32(3'd6, 64'd5, 64'd5, 1);
    drive32(3'd4, 64'hFFFF_FFFF, 64'h1, 1);
    drain();

    for (int i = 0; i < 16; i++)
      drive32(3'($urandom_range(0, 6)), 64'($urandom),
              64'($urandom), 1);
    drain();

    busy_cnt = 0;
    drive32(3'd7, 64'd1000, 64'd7, 1);
    for (int i = 0; i < 5; i++)
      drive32(3'd5, 64'd1, 64'd1, 0);
    drain();
    chk("mod_busy_cycles", 64'(busy_cnt), 64'd32);
    drive32(3'd7, 64'hDEAD_BEEF, 64'h0001_2345, 1);
    drain();

    busy_cnt = 0;
    drive32(3'd7, 64'h1234, 64'd0, 1);
    drain();
    chk("dbz_busy", 64'(busy_cnt), 64'd0);

    drive32(3'd7, 64'd1000, 64'd7, 0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'b0, if32.busy}, 64'd0);
    chk("abort_valid", {63'b0, if32.valid}, 64'd0);
    reset = 1'b1;
    drive32(3'd5, 64'd2, 64'd3, 1);
    drain();

    drive8(3'd7, 64'hFF, 64'h10);
    drain();
    drive8(3'd5, 64'h80, 64'h80);
    drive8(3'd6, 64'h80, 64'h01);
    drive8(3'd4, 64'h7F, 64'h80);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
